i2s_transmitter: RTL

Output stage downstream of the adaptive FIR. It takes stereo 16-bit signed samples on a ready pulse, holds them in a one-deep pending register, and serialises them as a Philips-I2S master stream (BCLK/LRCLK/SDATA) to an external DAC/amp. It runs from the 100 MHz system clock and uses the same slot format as i2s_receiver: 64 BCLKs per frame, 32-bit slots, 16 significant bits.

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_clkgen.sv | 67 ++++++
 rtl/i2s_transmitter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2s_pkg
// Purpose : Shared I2S slot format constants and stereo sample type.
// Revision: 1.0
// ============================================================================
package i2s_pkg;

  localparam int SLOT_W           = 32;
  localparam int FRAME_BITS       = 2 * SLOT_W;
  localparam int HALF_DIV_DEFAULT = 12;
  localparam int SAMPLE_W         = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module  : i2s_clkgen
// Purpose : BCLK divider, frame bit counter, LRCLK and fall/load strobes.
// Revision: 1.0
// ============================================================================
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = i2s_pkg::HALF_DIV_DEFAULT,
  parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic                          bclk_o,
  output logic                          lrclk_o,
  output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt_nxt_o,
  output logic                          fall_stb_o,
  output logic                          load_stb_o
);

  localparam int DW = $clog2(HALF_DIV);
  localparam int BW = $clog2(2*SLOT_W);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          wrap, fall, load;

  always_comb begin
    wrap      = (div_cnt_q == DW'(HALF_DIV-1));
    fall      = wrap & bclk_q;
    load      = fall & (bit_cnt_q == BW'(2*SLOT_W-1));
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q ^ wrap;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall) begin
      bit_cnt_d = load ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= BW'(SLOT_W));
    end
  end

  // Counter starts on the last bit so the first falling edge is a frame load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BW'(2*SLOT_W-1);
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign lrclk_o       = lrclk_q;
  assign bit_cnt_nxt_o = bit_cnt_d;
  assign fall_stb_o    = fall;
  assign load_stb_o    = load;

endmodule
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : i2s_transmitter
// Purpose : One-deep buffered stereo sample serialiser, Philips I2S master.
// Revision: 1.0
// ============================================================================
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = i2s_pkg::HALF_DIV_DEFAULT,
  parameter int SAMPLE_W = i2s_pkg::SAMPLE_W,
  parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                ready_in,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                i2s_bclk_out,
  output logic                i2s_lrclk_out,
  output logic                i2s_data_out,
  output logic                frame_start_out,
  output logic                underrun_out,
  output logic                overrun_out
);

  localparam int BW = $clog2(2*SLOT_W);

  logic [BW-1:0]       bit_nxt;
  logic                fall, load;

  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [SAMPLE_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic                pend_v_q, pend_v_d;
  logic                data_q, data_d;
  logic                fs_q, under_q, over_q;
  logic                under_d, over_d;
  logic                upper, bit_sel;
  logic [BW-1:0]       pos;
  logic [SAMPLE_W-1:0] chan;

  i2s_clkgen #(
    .HALF_DIV (HALF_DIV),
    .SLOT_W   (SLOT_W)
  ) u_clkgen (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .bclk_o        (i2s_bclk_out),
    .lrclk_o       (i2s_lrclk_out),
    .bit_cnt_nxt_o (bit_nxt),
    .fall_stb_o    (fall),
    .load_stb_o    (load)
  );

  always_comb begin
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    pend_v_d = pend_v_q;
    tx_l_d   = tx_l_q;
    tx_r_d   = tx_r_q;
    under_d  = 1'b0;
    over_d   = 1'b0;
    if (load) begin
      if (pend_v_q) begin
        tx_l_d   = pend_l_q;
        tx_r_d   = pend_r_q;
        pend_v_d = ready_in;
        if (ready_in) begin
          pend_l_d = left_in;
          pend_r_d = right_in;
        end
      end else if (ready_in) begin
        tx_l_d = left_in;
        tx_r_d = right_in;
      end else begin
        under_d = 1'b1;
      end
    end else if (ready_in) begin
      pend_l_d = left_in;
      pend_r_d = right_in;
      pend_v_d = 1'b1;
      over_d   = pend_v_q;
    end
  end

  // Slot position p sends sample bit SAMPLE_W-p for p = 1..SAMPLE_W, else 0.
  always_comb begin
    upper   = (bit_nxt >= BW'(SLOT_W));
    pos     = upper ? bit_nxt - BW'(SLOT_W) : bit_nxt;
    chan    = upper ? tx_r_d : tx_l_d;
    bit_sel = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (pos == BW'(SAMPLE_W - i)) begin
        bit_sel = chan[i];
      end
    end
    data_d = fall ? bit_sel : data_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_l_q <= '0;
      pend_r_q <= '0;
      pend_v_q <= 1'b0;
      tx_l_q   <= '0;
      tx_r_q   <= '0;
      data_q   <= 1'b0;
      fs_q     <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      pend_v_q <= pend_v_d;
      tx_l_q   <= tx_l_d;
      tx_r_q   <= tx_r_d;
      data_q   <= data_d;
      fs_q     <= load;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign i2s_data_out    = data_q;
  assign frame_start_out = fs_q;
  assign underrun_out    = under_q;
  assign overrun_out     = over_q;

endmodule
`default_nettype wire
